// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline controller and the CPU datapath.
// With STALL_WDOG_EN defined the bundle also carries stall_timeout_o.
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_flush_o;
    logic [31:0] stall_cycles_o;
`ifdef STALL_WDOG_EN
    logic        stall_timeout_o;

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excepttype_i, cp0_epc_i,
        output stall_o, flush_o, new_pc_o, busy_flush_o, stall_cycles_o,
        output stall_timeout_o
    );
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excepttype_i, cp0_epc_i,
        input  stall_o, flush_o, new_pc_o, busy_flush_o, stall_cycles_o,
        input  stall_timeout_o
    );
`else
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excepttype_i, cp0_epc_i,
        output stall_o, flush_o, new_pc_o, busy_flush_o, stall_cycles_o
    );
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excepttype_i, cp0_epc_i,
        input  stall_o, flush_o, new_pc_o, busy_flush_o, stall_cycles_o
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merging, exception/ERET redirect sequencing, stall counter.
// Optional stall watchdog enabled by defining STALL_WDOG_EN.
module pipe_ctrl #(
    parameter logic [31:0] INT_VECTOR    = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || STALL_TIMEOUT < 1) begin : g_param_check
        $error("pipe_ctrl: FLUSH_CYCLES must be 1..15 and STALL_TIMEOUT >= 1");
    end

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_flush_cnt, w_flush_cnt_nxt;
    logic [31:0] r_new_pc, w_new_pc_nxt, w_new_pc_out, w_vector;
    logic [31:0] r_stall_cycles;
    logic [5:0]  w_stall;
    logic        w_flush;

    // ERET returns to EPC; interrupts use INT_VECTOR; every other code goes to EXC_VECTOR.
    always_comb begin
        case (bus.excepttype_i)
            32'h0000_0001: w_vector = INT_VECTOR;
            32'h0000_000e: w_vector = bus.cp0_epc_i;
            default:       w_vector = EXC_VECTOR;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_new_pc_nxt    = r_new_pc;
        w_new_pc_out    = r_new_pc;
        w_stall         = 6'b000000;
        w_flush         = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.excepttype_i != 32'h0) begin
                    w_flush      = 1'b1;
                    w_new_pc_out = w_vector;
                    w_new_pc_nxt = w_vector;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
                    end
                end else if (bus.stallreq_mem_i) begin
                    w_stall = 6'b011111;
                end else if (bus.stallreq_ex_i) begin
                    w_stall = 6'b001111;
                end else if (bus.stallreq_id_i) begin
                    w_stall = 6'b000111;
                end else if (bus.stallreq_if_i) begin
                    w_stall = 6'b000011;
                end
            end
            ST_FLUSH: begin
                // Inputs here belong to squashed instructions and are ignored.
                w_flush = 1'b1;
                if (r_flush_cnt <= 4'd1) begin
                    w_state_nxt     = ST_RUN;
                    w_flush_cnt_nxt = 4'd0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_flush_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_flush_cnt    <= 4'd0;
            r_new_pc       <= 32'h0;
            r_stall_cycles <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_new_pc    <= w_new_pc_nxt;
            if (w_stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

`ifdef STALL_WDOG_EN
    logic [31:0] r_run_len;
    logic        r_timeout;

    // Run length saturates at the limit; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_len <= 32'h0;
            r_timeout <= 1'b0;
        end else if (w_stall[0]) begin
            if (r_run_len < 32'(STALL_TIMEOUT)) r_run_len <= r_run_len + 32'd1;
            if (r_run_len >= 32'(STALL_TIMEOUT - 1)) r_timeout <= 1'b1;
        end else begin
            r_run_len <= 32'h0;
        end
    end

    assign bus.stall_timeout_o = r_timeout;
`endif

    assign bus.stall_o        = w_stall;
    assign bus.flush_o        = w_flush;
    assign bus.new_pc_o       = w_new_pc_out;
    assign bus.busy_flush_o   = (r_state == ST_FLUSH);
    assign bus.stall_cycles_o = r_stall_cycles;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: three instances with FLUSH_CYCLES of 1, 3 and 4.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus1();
  pipe_ctrl_if bus3();
  pipe_ctrl_if bus4();

  pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  pipe_ctrl #(.FLUSH_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic clear_inputs();
    bus1.stallreq_if_i = 0; bus1.stallreq_id_i = 0; bus1.stallreq_ex_i = 0; bus1.stallreq_mem_i = 0;
    bus1.excepttype_i = 0; bus1.cp0_epc_i = 0;
    bus3.stallreq_if_i = 0; bus3.stallreq_id_i = 0; bus3.stallreq_ex_i = 0; bus3.stallreq_mem_i = 0;
    bus3.excepttype_i = 0; bus3.cp0_epc_i = 0;
    bus4.stallreq_if_i = 0; bus4.stallreq_id_i = 0; bus4.stallreq_ex_i = 0; bus4.stallreq_mem_i = 0;
    bus4.excepttype_i = 0; bus4.cp0_epc_i = 0;
  endtask

  // Leaves the bench at negedge+2 with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus1.stall_o !== 6'b0 || bus1.flush_o !== 1'b0 || bus1.new_pc_o !== 32'h0 ||
          bus1.stall_cycles_o !== 32'h0 || bus1.busy_flush_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: stall=%b flush=%b pc=%h cnt=%0d busy=%b, want all 0",
                 i, bus1.stall_o, bus1.flush_o, bus1.new_pc_o, bus1.stall_cycles_o, bus1.busy_flush_o);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall_merge();
    do_reset();
    bus1.stallreq_id_i = 1; bus1.stallreq_mem_i = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus1.stall_o !== 6'b011111) begin
        errors++;
        $display("FAIL stall_id_mem cyc %0d: stall=%b want 011111", i, bus1.stall_o);
      end
      next_cycle();
    end
    bus1.stallreq_id_i = 0; bus1.stallreq_mem_i = 0;
    #1;
    checks++;
    if (bus1.stall_cycles_o !== 32'd3) begin
      errors++;
      $display("FAIL stall_count: got %0d want 3", bus1.stall_cycles_o);
    end
    checks++;
    if (bus1.stall_o !== 6'b0) begin
      errors++;
      $display("FAIL stall_release: stall=%b want 000000", bus1.stall_o);
    end
  endtask

  task automatic test_priority();
    logic [3:0]  req [4]  = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    logic [5:0]  exp [4]  = '{6'b011111, 6'b001111, 6'b000111, 6'b000011};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus1.stallreq_mem_i = req[i][3]; bus1.stallreq_ex_i = req[i][2];
      bus1.stallreq_id_i  = req[i][1]; bus1.stallreq_if_i = req[i][0];
      #1;
      checks++;
      if (bus1.stall_o !== exp[i]) begin
        errors++;
        $display("FAIL stall_priority req=%b: stall=%b want %b", req[i], bus1.stall_o, exp[i]);
      end
      next_cycle();
    end
    bus1.stallreq_if_i = 0;
    #1;
    checks++;
    if (bus1.stall_cycles_o !== 32'd4) begin
      errors++;
      $display("FAIL priority_count: got %0d want 4", bus1.stall_cycles_o);
    end
  endtask

  task automatic test_exception();
    logic [31:0] codes [4] = '{32'h1, 32'h8, 32'he, 32'h3};
    logic [31:0] pcs   [4] = '{32'h20, 32'h40, 32'h0000_5678, 32'h40};
    do_reset();
    bus1.excepttype_i = 32'h1; bus1.stallreq_ex_i = 1;
    #1;
    checks++;
    if (bus1.flush_o !== 1'b1 || bus1.new_pc_o !== 32'h20 || bus1.stall_o !== 6'b0) begin
      errors++;
      $display("FAIL exc_int_vs_stall: flush=%b pc=%h stall=%b want 1 00000020 000000",
               bus1.flush_o, bus1.new_pc_o, bus1.stall_o);
    end
    next_cycle();
    bus1.excepttype_i = 0; bus1.stallreq_ex_i = 0;
    #1;
    checks++;
    if (bus1.flush_o !== 1'b0 || bus1.new_pc_o !== 32'h20 || bus1.busy_flush_o !== 1'b0 ||
        bus1.stall_cycles_o !== 32'd0) begin
      errors++;
      $display("FAIL exc_int_after: flush=%b pc=%h busy=%b cnt=%0d want 0 00000020 0 0",
               bus1.flush_o, bus1.new_pc_o, bus1.busy_flush_o, bus1.stall_cycles_o);
    end
    for (int i = 0; i < 4; i++) begin
      bus1.excepttype_i = codes[i]; bus1.cp0_epc_i = 32'h0000_5678;
      #1;
      checks++;
      if (bus1.flush_o !== 1'b1 || bus1.new_pc_o !== pcs[i]) begin
        errors++;
        $display("FAIL exc_decode code=%h: flush=%b pc=%h want 1 %h",
                 codes[i], bus1.flush_o, bus1.new_pc_o, pcs[i]);
      end
      next_cycle();
    end
    bus1.excepttype_i = 0; bus1.cp0_epc_i = 0;
  endtask

  task automatic test_multi_flush();
    logic [3:0] flush_seen;
    do_reset();
    flush_seen = 4'b0;
    bus3.excepttype_i = 32'he; bus3.cp0_epc_i = 32'h0000_1234;
    #1;
    for (int i = 0; i < 4; i++) begin
      flush_seen[i] = bus3.flush_o;
      checks++;
      if (bus3.new_pc_o !== 32'h0000_1234 || bus3.stall_o !== 6'b0) begin
        errors++;
        $display("FAIL eret_flush cyc %0d: pc=%h stall=%b want 00001234 000000",
                 i, bus3.new_pc_o, bus3.stall_o);
      end
      checks++;
      if (bus3.busy_flush_o !== (i == 1 || i == 2)) begin
        errors++;
        $display("FAIL eret_busy cyc %0d: busy=%b want %b", i, bus3.busy_flush_o, (i == 1 || i == 2));
      end
      next_cycle();
      if (i == 0) begin
        bus3.excepttype_i = 32'h8; bus3.stallreq_mem_i = 1;
      end else begin
        bus3.excepttype_i = 0; bus3.stallreq_mem_i = 0;
      end
      #1;
    end
    checks++;
    if (flush_seen !== 4'b0111) begin
      errors++;
      $display("FAIL eret_flush_len: flush pattern=%b want 0111", flush_seen);
    end
    checks++;
    if (bus3.stall_cycles_o !== 32'd0) begin
      errors++;
      $display("FAIL eret_stall_ignored: cnt=%0d want 0", bus3.stall_cycles_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    bus4.excepttype_i = 32'h3;
    #1;
    checks++;
    if (bus4.flush_o !== 1'b1 || bus4.new_pc_o !== 32'h40) begin
      errors++;
      $display("FAIL rstflush_start: flush=%b pc=%h want 1 00000040", bus4.flush_o, bus4.new_pc_o);
    end
    next_cycle();
    bus4.excepttype_i = 0;
    #1;
    checks++;
    if (bus4.flush_o !== 1'b1 || bus4.busy_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL rstflush_second: flush=%b busy=%b want 1 1", bus4.flush_o, bus4.busy_flush_o);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus4.flush_o !== 1'b0 || bus4.busy_flush_o !== 1'b0 || bus4.new_pc_o !== 32'h0) begin
        errors++;
        $display("FAIL rstflush_after cyc %0d: flush=%b busy=%b pc=%h want 0 0 0",
                 i, bus4.flush_o, bus4.busy_flush_o, bus4.new_pc_o);
      end
      next_cycle();
    end
  endtask

`ifdef STALL_WDOG_EN
  task automatic test_watchdog();
    do_reset();
    bus1.stallreq_if_i = 1;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus1.stall_timeout_o !== (i >= 8) || bus1.stall_o !== 6'b000011) begin
        errors++;
        $display("FAIL wdog_stall cyc %0d: timeout=%b stall=%b want %b 000011",
                 i, bus1.stall_timeout_o, bus1.stall_o, (i >= 8));
      end
      next_cycle();
    end
    bus1.stallreq_if_i = 0;
    bus1.excepttype_i = 32'h1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus1.stall_timeout_o !== 1'b1) begin
        errors++;
        $display("FAIL wdog_sticky cyc %0d: timeout=%b want 1", i, bus1.stall_timeout_o);
      end
      next_cycle();
      bus1.excepttype_i = 0;
    end
    do_reset();
    checks++;
    if (bus1.stall_timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL wdog_reset: timeout=%b want 0", bus1.stall_timeout_o);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_stall_merge();
    test_priority();
    test_exception();
    test_multi_flush();
    test_reset_mid_flush();
`ifdef STALL_WDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and the pipeline latches. It sequences exception/ERET redirection: flush_o is asserted for a programmable number of cycles while new_pc_o carries the handler or EPC target. It also keeps a stall-cycle counter for debug.

Parameters:
INT_VECTOR, 32'h00000020, redirect target for interrupts
EXC_VECTOR, 32'h00000040, redirect target for all other exceptions
FLUSH_CYCLES, 1, cycles flush_o stays high per redirect (1..15)
STALL_TIMEOUT, 1024, watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if_i  in  1  instruction-fetch bus not ready
stallreq_id_i  in  1  ID-stage hazard stall (load-use)
stallreq_ex_i  in  1  EX multi-cycle op (div/madd) busy
stallreq_mem_i  in  1  data bus not ready
excepttype_i  in  32  MEM-stage exception code, 0 = none
cp0_epc_i  in  32  current EPC from CP0
stall_o  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1 = hold
flush_o  out  1  clear all pipeline latches, PC loads new_pc_o
new_pc_o  out  32  redirect target, valid while flush_o=1
busy_flush_o  out  1  high while FSM is in FLUSH
stall_cycles_o  out  32  count of cycles with stall_o[0]=1, wraps at 2^32

Behaviour:
- Reset: state RUN, flush counter 0, stall_o=0, flush_o=0, new_pc_o=0, busy_flush_o=0, stall_cycles_o=0.
- FSM states: RUN and FLUSH.
- RUN, excepttype_i != 0:
  - flush_o=1 in the same cycle (combinational), stall_o=0.
  - new_pc_o decode: 0x1 -> INT_VECTOR; 0x8/0x9/0xa/0xc/0xd -> EXC_VECTOR; 0xe (ERET) -> cp0_epc_i; any other nonzero code -> EXC_VECTOR.
  - new_pc_o is latched into a register.
  - If FLUSH_CYCLES > 1, go to FLUSH with counter = FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, no exception: flush_o=0 and new_pc_o holds its last latched value. stall_o by priority, highest wins:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 6'b000000
- FLUSH:
  - flush_o=1, new_pc_o = latched value, stall_o=0, busy_flush_o=1.
  - All stall requests and excepttype_i are ignored; they belong to squashed instructions.
  - Counter decrements each cycle; at 1, return to RUN on the next edge.
- Exception and stall request in the same RUN cycle: exception wins, stall_o=0.
- stall_cycles_o increments on every edge where stall_o[0]=1; it saturates never, wraps modulo 2^32.
- Reset mid-FLUSH: immediately RUN, flush_o=0 on the cycle after the reset edge, counters cleared.
- Consumer rule: flush_o overrides stall and branch in the PC register; PC loads new_pc_o on that edge.

Optional Feature:
STALL_WDOG_EN: adds output stall_timeout_o (1 bit) and an internal run-length counter.
- Counter increments while stall_o[0]=1 and clears when stall_o[0]=0.
- When the counter reaches STALL_TIMEOUT, stall_timeout_o goes high and stays high (sticky) until rst.
- A flush does not clear it.
- Without the macro: no port, no counter, and no other behaviour changes.

Test Plan:
- Reset, then idle 5 cycles -> stall_o=0, flush_o=0, new_pc_o=0, stall_cycles_o=0.
- stallreq_id_i=1 and stallreq_mem_i=1 together for 3 cycles -> stall_o=6'b011111 each cycle, stall_cycles_o=3 afterwards.
- excepttype_i=0x1 with stallreq_ex_i=1 in the same cycle -> flush_o=1, new_pc_o=0x00000020, stall_o=0 that cycle; next cycle flush_o=0.
- FLUSH_CYCLES=3, excepttype_i=0xe, cp0_epc_i=0x00001234, then excepttype_i=0x8 on the next cycle -> flush_o high exactly 3 cycles, new_pc_o=0x00001234 throughout, second exception ignored.
- FLUSH_CYCLES=4, rst pulsed in 2nd flush cycle -> flush_o=0 and busy_flush_o=0 from the following cycle.
- With STALL_WDOG_EN and STALL_TIMEOUT=8, hold stallreq_if_i for 10 cycles, then release -> stall_timeout_o rises after the 8th stalled cycle and remains 1 until rst.
